flit_traffic_gen: RTL
=====================

# flit_traffic_gen

- Synthesisable, parametrised flit stimulus source for energy characterisation of arithmetic blocks (adders, multipliers) under controlled link utilisation.
- Emits NUM_PKT packets of PAYLOAD flits, each followed by GAP idle cycles. Each 2N-bit flit pattern is split into two N-bit operands.
- Replaces hand-written testbench case tables with a hardware generator that supports valid/ready backpressure and two activity modes (Johnson thermometer, LFSR).

## Interface
- N, 13: operand width; pattern register is 2N bits.
- PAYLOAD, 20: flits per packet, ≥1.
- GAP, 7: idle cycles after each packet except the last, ≥0.
- NUM_PKT, 10: packets per run; 0 = run until reset.
- LFSR_SEED, 1: mode-1 initial pattern; a value of 0 is replaced by 1.
- LFSR_TAPS, 26'h2000023: Galois feedback mask; the default gives x^26+x^6+x^2+x+1 for 2N=26.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a run; honoured only in IDLE or DONE.
- mode  in  1  0 = Johnson, 1 = LFSR; sampled when start is accepted.
- ready  in  1  downstream accepts the current flit.
- valid  out  1  flit present on input1/input2.
- input1  out  N  pattern bits [N-1:0].
- input2  out  N  pattern bits [2N-1:N].
- sop  out  1  valid && first flit of the packet.
- eop  out  1  valid && last flit of the packet.
- busy  out  1  state is SEND or GAP.
- done  out  1  run complete; sticky until the next start.
- pkt_cnt  out  16  packets fully accepted in this run.

## Operation
- States and transitions:
  - IDLE: start → SEND; load pattern P; clear counters.
  - SEND: valid=1. On each handshake (valid&&ready), flit_cnt++ and P steps. On an accepted eop: pkt_cnt++, flit_cnt=0, then:
    - if NUM_PKT≠0 and pkt_cnt reaches NUM_PKT → DONE;
    - else if GAP=0 → stay in SEND;
    - else → GAP.
  - GAP: valid=0; gap_cnt counts GAP cycles, then → SEND.
  - DONE: done=1, valid=0; start → SEND and clears pkt_cnt/done.
- Pattern step:
  - mode 0 (Johnson): P' = {P[2N-2:0], ~P[2N-1]}; initial P=0; period 4N.
  - mode 1 (Galois): P' = (P>>1) ^ (P[0] ? LFSR_TAPS : 0); initial P=LFSR_SEED.
- P persists across packets and is reloaded only on start. The first flit of a run shows the initial P.
- Backpressure: while valid && !ready, input1/input2/sop/eop hold stable and flit_cnt does not advance.
- start during SEND/GAP: ignored. mode changes mid-run: ignored.
- Reset at any time: immediately → IDLE; all outputs 0; P=0.
- Counter widths: flit_cnt $clog2(PAYLOAD+1), gap_cnt $clog2(GAP+1). pkt_cnt wraps modulo 2^16 when NUM_PKT=0.

## Timing
- Reset values: valid, sop, eop, busy, done = 0; input1 = input2 = 0; pkt_cnt = 0.
- start sampled at edge t → valid=1, sop=1 from edge t+1.
- All outputs are driven from flops or decoded from state flops only. No combinational path from ready or start to any output.
- Accepted eop at edge t, GAP=g>0 → valid low for cycles t+1..t+g, high again at t+g+1. With g=0, valid stays high and the next sop follows at t+1.
- Final eop accepted at edge t → done=1 and busy=0 from t+1.
- With ready=1, the run lasts 1 + NUM_PKT·PAYLOAD + (NUM_PKT−1)·GAP cycles from the start edge to done.

## Configuration
- FLIT_GEN_IDLE_ZERO_EN defined: input1/input2 are forced to 0 whenever valid=0 (IDLE, GAP, DONE). This models return-to-zero links.
- FLIT_GEN_IDLE_ZERO_EN undefined: input1/input2 hold the last presented pattern while valid=0, giving zero operand toggling during idle.

## Structure
- Package flit_gen_pkg: state enum (IDLE, SEND, GAP, DONE), mode encodings (MODE_JOHNSON=0, MODE_LFSR=1), default LFSR_TAPS constant.
- Sub-module flit_pattern_step: holds P and provides load/step for both modes, with ports load, step, mode, seed and pattern.
- The top level holds the FSM, the counters and output decode.

## Test plan
- Default parameters, mode 0, ready=1, start pulse → done at exactly +264 cycles; pkt_cnt=10; 200 valid cycles.
- Mode 0 pattern check → flits 0..3 are P=0,1,3,7; flit 26 is input1=1FFF, input2=1FFF; flit 27 is input1=1FFE, input2=1FFF.
- Mode 1, seed 1 → flit 0 is input1=0001, input2=0000; flit 1 is input1=0023, input2=1000.
- ready held low 5 cycles mid-packet → outputs stable, flit_cnt frozen, no flits lost or duplicated; eop still on the 20th accepted flit.
- PAYLOAD=1, GAP=0, NUM_PKT=3 → sop=eop=1 on every valid flit; valid continuous for 3 cycles; then done.
- rst_n asserted mid-SEND, then start → all outputs 0 immediately; the next run restarts from the initial pattern with pkt_cnt=0.

Source files
------------

// File: rtl/flit_gen_pkg.sv
// Shared definitions for flit_traffic_gen: FSM state encodings, activity-mode encodings
// and the default Galois feedback mask.
package flit_gen_pkg;

  typedef logic [1:0] state_e;

  localparam state_e ST_IDLE = 2'd0;
  localparam state_e ST_SEND = 2'd1;
  localparam state_e ST_GAP  = 2'd2;
  localparam state_e ST_DONE = 2'd3;

  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_LFSR    = 1'b1;

  // x^26 + x^6 + x^2 + x + 1 for a 26-bit pattern.
  localparam logic [25:0] DEFAULT_LFSR_TAPS = 26'h2000023;

endpackage

// File: rtl/flit_pattern_step.sv
// Pattern register P for flit_traffic_gen: load selects the initial value for the chosen
// mode (latched at load), step advances it as a Johnson counter or a Galois LFSR.
module flit_pattern_step
  import flit_gen_pkg::*;
#(
  parameter int unsigned     W    = 26,
  parameter logic [W-1:0]    TAPS = W'(DEFAULT_LFSR_TAPS)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic         mode,
  input  logic [W-1:0] seed,
  output logic [W-1:0] pattern
);

  logic [W-1:0] pat_q, pat_d;
  logic         mode_q, mode_d;
  logic [W-1:0] seed_fixed;
  logic [W-1:0] johnson_next;
  logic [W-1:0] lfsr_next;

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  assign seed_fixed   = (seed == '0) ? W'(1) : seed;
  assign johnson_next = {pat_q[W-2:0], ~pat_q[W-1]};
  assign lfsr_next    = (pat_q >> 1) ^ (pat_q[0] ? TAPS : '0);

  always_comb begin
    pat_d  = pat_q;
    mode_d = mode_q;
    if (load) begin
      mode_d = mode;
      pat_d  = (mode == MODE_LFSR) ? seed_fixed : '0;
    end else if (step) begin
      pat_d = (mode_q == MODE_LFSR) ? lfsr_next : johnson_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= '0;
      mode_q <= MODE_JOHNSON;
    end else begin
      pat_q  <= pat_d;
      mode_q <= mode_d;
    end
  end

  assign pattern = pat_q;

endmodule

// File: rtl/flit_traffic_gen.sv
// Flit stimulus source: NUM_PKT packets of PAYLOAD flits separated by GAP idle cycles.
// Define FLIT_GEN_IDLE_ZERO_EN to force input1/input2 to zero whenever valid is low.
module flit_traffic_gen
  import flit_gen_pkg::*;
#(
  parameter int unsigned      N         = 13,
  parameter int unsigned      PAYLOAD   = 20,
  parameter int unsigned      GAP       = 7,
  parameter int unsigned      NUM_PKT   = 10,
  parameter logic [2*N-1:0]   LFSR_SEED = (2*N)'(1),
  parameter logic [2*N-1:0]   LFSR_TAPS = (2*N)'(DEFAULT_LFSR_TAPS)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic         ready,
  output logic         valid,
  output logic [N-1:0] input1,
  output logic [N-1:0] input2,
  output logic         sop,
  output logic         eop,
  output logic         busy,
  output logic         done,
  output logic [15:0]  pkt_cnt
);

  localparam int unsigned FW = $clog2(PAYLOAD + 1);
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [FW-1:0] FLIT_LAST = FW'(PAYLOAD - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

  state_e          state_q, state_d;
  logic [FW-1:0]   flit_cnt_q, flit_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;
  logic            load, step;
  logic [2*N-1:0]  pattern;

  flit_pattern_step #(
    .W    (2 * N),
    .TAPS (LFSR_TAPS)
  ) u_pattern (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .mode    (mode),
    .seed    (LFSR_SEED),
    .pattern (pattern)
  );

  // P is stepped only when another flit follows immediately, or on leaving GAP, so the
  // pattern register itself holds the last presented flit while valid is low.
  always_comb begin
    state_d    = state_q;
    flit_cnt_d = flit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_SEND;
          load       = 1'b1;
          flit_cnt_d = '0;
          gap_cnt_d  = '0;
          pkt_cnt_d  = '0;
        end
      end
      ST_SEND: begin
        if (ready) begin
          if (flit_cnt_q == FLIT_LAST) begin
            flit_cnt_d = '0;
            pkt_cnt_d  = pkt_cnt_q + 16'd1;
            if ((NUM_PKT != 0) && (pkt_cnt_d == 16'(NUM_PKT))) begin
              state_d = ST_DONE;
            end else if (GAP == 0) begin
              step = 1'b1;
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = '0;
            end
          end else begin
            flit_cnt_d = flit_cnt_q + 1'b1;
            step       = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_SEND;
          gap_cnt_d = '0;
          step      = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      flit_cnt_q <= '0;
      gap_cnt_q  <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      flit_cnt_q <= flit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign valid   = (state_q == ST_SEND);
  assign sop     = valid && (flit_cnt_q == '0);
  assign eop     = valid && (flit_cnt_q == FLIT_LAST);
  assign busy    = (state_q == ST_SEND) || (state_q == ST_GAP);
  assign done    = (state_q == ST_DONE);
  assign pkt_cnt = pkt_cnt_q;

`ifdef FLIT_GEN_IDLE_ZERO_EN
  assign input1 = valid ? pattern[N-1:0]   : '0;
  assign input2 = valid ? pattern[2*N-1:N] : '0;
`else
  assign input1 = pattern[N-1:0];
  assign input2 = pattern[2*N-1:N];
`endif

endmodule
